shift_unit_seq: RTL
===================

# shift_unit_seq

Multi-cycle variable-amount shifter for the datapath's shift instructions (sll/srl/sra, plus rotate-right). It complements the fixed left-shift paths (×4 branch offset, upper-half load) with general left, logical-right, arithmetic-right and rotate shifts. It processes up to STEP bit positions per cycle, which trades latency for a small, short-critical-path shifter. A start/busy/done handshake lets the control unit stall the pipeline until the result is ready.

## Interface
- STEP, 4, maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16, 32
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when the unit is not busy
- mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- amt  in  5  shift amount, 0–31
- data_in  in  32  operand
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  32  shifted value; held until the next accepted start

## Operation
- States: IDLE, RUN, DONE. Encoding 2 bits.
- IDLE or DONE, start=1: latch data_in into the work register, amt into rem, and mode into mode_r; go to RUN. mode, amt and data_in are not sampled again for this operation.
- IDLE or DONE, start=0: go to or stay in IDLE.
- RUN: k = min(rem, STEP). Work register ← one step by k under mode_r; rem ← rem − k.
  - If the new rem = 0, go to DONE.
  - rem = 0 on entry (amt=0) gives exactly one RUN cycle with k=0.
- Step semantics:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with bit 31 of the current work register.
  - ROR: bits leaving bit 0 enter at bit 31.
- DONE: result ← work register; done=1 for this cycle only.
- busy = 1 exactly in RUN. start while busy is ignored, with no queuing and no effect on the operation in flight.
- Reset (rst_n=0 at an edge), from any state, including mid-RUN:
  - state IDLE; busy 0; done 0; result 0x00000000; rem 0; work register 0.
  - The operation in flight is discarded and done never pulses for it.

## Timing
- Start accepted at edge 0. RUN occupies cycles 1..N, with N = max(1, ceil(amt/STEP)). done=1 and result is valid in cycle N+1.
- With STEP=4:
  - amt=0 → done in cycle 2.
  - amt=16 → done in cycle 5.
  - amt=31 → done in cycle 9.
- STEP=32: every operation takes N=1, and done is always in cycle 2.
- Back-to-back: start=1 during the DONE cycle is accepted, so RUN begins the next cycle with no IDLE bubble.
- result changes only on the edge entering DONE (and on reset). It is stable in every other cycle.

## Structure
- Shared package shift_pkg:
  - mode constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR.
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module shift_step: purely combinational.
  - Inputs: 32-bit value, mode, k of width clog2(STEP)+1.
  - Output: the value shifted by k, k ≤ STEP.
  - Instantiated once in the RUN datapath.
- Top level holds the FSM, rem counter, work register and result register.

## Test plan
All scenarios use STEP=4; cycle 0 is the cycle whose edge accepts start.
- SRA, data_in 0x80000000, amt 31 → result 0xFFFFFFFF, done in cycle 9, busy high in cycles 1–8.
- SRL, data_in 0x80000000, amt 31 → 0x00000001. SLL, data_in 0x00001234, amt 16 → 0x12340000, done in cycle 5.
- ROR, data_in 0x0000000F, amt 4 → 0xF0000000, done in cycle 2. Any mode with amt 0, data_in 0xDEADBEEF → 0xDEADBEEF, done in cycle 2.
- Start SLL 0x1 amt 20, then pulse start with SRL 0xFFFFFFFF amt 1 in cycle 2 → the second request is ignored; result 0x00100000, done in cycle 6, exactly one done pulse.
- Back-to-back: start SLL 0x3 amt 1, then start SRL 0x8 amt 3 during the DONE cycle → results 0x6 (cycle 2) then 0x1 (cycle 4). result is stable in between.
- Reset mid-RUN (rst_n=0 in cycle 3 of an amt=31 operation) → next cycle: busy 0, done 0, result 0x00000000, and no later done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: mode and FSM state encodings shared by the sequential shifter.
package shift_pkg;
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-step shift of up to STEP positions under a given mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 4,
  localparam int KW = $clog2(STEP) + 1
) (
  input  logic [31:0]   val_i,
  input  logic [1:0]    mode_i,
  input  logic [KW-1:0] k_i,
  output logic [31:0]   val_o
);
  // A left shift by 32 yields zero, so ROR with k=0 degrades cleanly to the identity.
  always_comb
    val_o = (mode_i == MODE_SLL) ? val_i << k_i
          : (mode_i == MODE_SRL) ? val_i >> k_i
          : (mode_i == MODE_SRA) ? 32'($signed(val_i) >>> k_i)
          : (val_i >> k_i) | (val_i << (6'd32 - 6'(k_i)));
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle SLL/SRL/SRA/ROR shifter, up to STEP positions per cycle,
// with start/busy/done handshake.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [4:0]  amt,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int KW = $clog2(STEP) + 1;
  state_t      state_q, state_d;
  logic [31:0] work_q, step_val, result_q;
  logic [4:0]  rem_q, rem_d;
  logic [5:0]  rem_w;
  logic [1:0]  mode_q;
  logic [KW-1:0] k;
  // Widen rem so the STEP=32 comparison does not wrap.
  assign rem_w = {1'b0, rem_q};
  assign k     = (rem_w < 6'(STEP)) ? KW'(rem_w) : KW'(STEP);
  assign rem_d = rem_q - 5'(k);
  shift_step #(.STEP(STEP)) u_step (
    .val_i (work_q),
    .mode_i(mode_q),
    .k_i   (k),
    .val_o (step_val)
  );
  always_ff @(posedge clk)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = (state_q == ST_RUN) ? ((rem_d == 5'd0) ? ST_DONE : ST_RUN)
            : (start ? ST_RUN : ST_IDLE);
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end
  // result is captured on the edge entering DONE so it is valid during the done pulse.
  always_ff @(posedge clk)
    if (!rst_n) begin
      work_q   <= '0;
      rem_q    <= '0;
      mode_q   <= MODE_SLL;
      result_q <= '0;
    end else if (state_q != ST_RUN && start) begin
      work_q <= data_in;
      rem_q  <= amt;
      mode_q <= mode;
    end else if (state_q == ST_RUN) begin
      work_q <= step_val;
      rem_q  <= rem_d;
      if (rem_d == 5'd0) result_q <= step_val;
    end
  assign result = result_q;
endmodule
